// File: rtl/time_set_editor.sv
// Time-setting editor: BCD hours/minutes/seconds edited by push buttons,
// with a one-cycle store strobe and an edit lock while the RTC write runs.
module time_set_editor #(
  parameter int unsigned BUSY_CYCLES = 112
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_save,
  output logic [7:0] hora,
  output logic [7:0] min,
  output logic [7:0] seg,
  output logic [1:0] field,
  output logic       chs,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(BUSY_CYCLES + 1);
  localparam int unsigned NBTN  = 5;

  typedef enum logic {EDIT, LOCK} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [NBTN-1:0]   btn, s1, s2, s3, ev;
  logic              is_hours;
  logic [7:0]        cur, top, up_val, dn_val, new_val;
  logic [1:0]        field_right, field_left;

  // Bit order doubles as priority: save > up > down > right > left
  assign btn = {btn_save, btn_up, btn_down, btn_right, btn_left};
  assign ev  = s2 & ~s3;

  function automatic logic [7:0] bcd_up(input logic [7:0] v, input logic [7:0] lim);
    if (v == lim)          return 8'h00;
    if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dn(input logic [7:0] v, input logic [7:0] lim);
    if (v == 8'h00)        return lim;
    if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // Selected field value and its edited candidates; field 3 acts as hours
  always_comb begin
    is_hours = 1'b1;
    cur      = hora;
    case (field)
      2'd1:    begin is_hours = 1'b0; cur = min; end
      2'd2:    begin is_hours = 1'b0; cur = seg; end
      default: begin is_hours = 1'b1; cur = hora; end
    endcase
    top     = is_hours ? 8'h23 : 8'h59;
    up_val  = bcd_up(cur, top);
    dn_val  = bcd_dn(cur, top);
    new_val = ev[3] ? up_val : dn_val;
  end

  always_comb begin
    field_right = 2'd0;
    field_left  = 2'd2;
    case (field)
      2'd0:    begin field_right = 2'd1; field_left = 2'd2; end
      2'd1:    begin field_right = 2'd2; field_left = 2'd0; end
      2'd2:    begin field_right = 2'd0; field_left = 2'd1; end
      default: begin field_right = 2'd0; field_left = 2'd2; end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      s3    <= '0;
      state <= EDIT;
      cnt   <= '0;
      hora  <= 8'h00;
      min   <= 8'h00;
      seg   <= 8'h00;
      field <= 2'd0;
      chs   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      s1  <= btn;
      s2  <= s1;
      s3  <= s2;
      chs <= 1'b0;
      case (state)
        EDIT: begin
          if (ev[4]) begin
            chs   <= 1'b1;
            busy  <= 1'b1;
            cnt   <= CNT_W'(BUSY_CYCLES - 1);
            state <= LOCK;
          end else if (ev[3] || ev[2]) begin
            case (field)
              2'd1:    min  <= new_val;
              2'd2:    seg  <= new_val;
              default: hora <= new_val;
            endcase
          end else if (ev[1]) begin
            field <= field_right;
          end else if (ev[0]) begin
            field <= field_left;
          end
        end
        LOCK: begin
          // Events keep flowing through s3 here, so edges seen in LOCK are consumed
          if (cnt == '0) begin
            state <= EDIT;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= EDIT;
      endcase
    end
  end

endmodule

// File: tb/tb_time_set_editor.sv
// Directed bench for time_set_editor: vector table for edits plus
// hand sequences for hold, store/lock, priority and reset-in-lock.
module tb_time_set_editor;

  logic       clock, reset;
  logic       btn_up, btn_down, btn_left, btn_right, btn_save;
  logic [7:0] hora, min, seg;
  logic [1:0] field;
  logic       chs, busy;

  int n_vec = 0;
  int n_err = 0;

  time_set_editor #(.BUSY_CYCLES(112)) dut (
    .clock(clock), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_save(btn_save),
    .hora(hora), .min(min), .seg(seg), .field(field),
    .chs(chs), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // buttons packed as {save, up, down, right, left}
  typedef struct {
    logic [4:0] btns;
    logic [7:0] h, m, s;
    logic [1:0] f;
  } vec_t;

  localparam logic [4:0] B_SAVE = 5'b10000, B_UP = 5'b01000, B_DN = 5'b00100,
                         B_RT = 5'b00010, B_LT = 5'b00001;
  localparam int NV = 45;
  vec_t vecs[NV];

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btn_save, btn_up, btn_down, btn_right, btn_left} = b;
  endtask

  task automatic press(input logic [4:0] b);
    @(negedge clock);
    set_btns(b);
    repeat (3) @(posedge clock);
    @(negedge clock);
    set_btns(5'b0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clock); #1;
      if (!busy) break;
    end
    chk("idle_timeout", 64'(k < 300), 64'(1));
  endtask

  initial begin
    logic [7:0] ch, cm, cs;
    logic [1:0] cf;
    int bcnt, bad;

    // Build vector table from a tiny reference of field behaviour
    ch = 8'h00; cm = 8'h00; cs = 8'h00; cf = 2'd0;
    for (int i = 0; i < 24; i++) vecs[i] = '{B_UP, bcd((i + 1) % 24), 8'h00, 8'h00, 2'd0};
    vecs[24] = '{B_RT, 8'h00, 8'h00, 8'h00, 2'd1};
    vecs[25] = '{B_DN, 8'h00, 8'h59, 8'h00, 2'd1};
    for (int k = 0; k < 10; k++) vecs[26 + k] = '{B_DN, 8'h00, bcd(58 - k), 8'h00, 2'd1};
    vecs[36] = '{B_UP, 8'h00, 8'h50, 8'h00, 2'd1};
    vecs[37] = '{B_LT, 8'h00, 8'h50, 8'h00, 2'd0};
    vecs[38] = '{B_LT, 8'h00, 8'h50, 8'h00, 2'd2};
    vecs[39] = '{B_DN, 8'h00, 8'h50, 8'h59, 2'd2};
    vecs[40] = '{B_UP, 8'h00, 8'h50, 8'h00, 2'd2};
    vecs[41] = '{B_UP | B_RT, 8'h00, 8'h50, 8'h01, 2'd2};
    vecs[42] = '{B_RT, 8'h00, 8'h50, 8'h01, 2'd0};
    vecs[43] = '{B_DN, 8'h23, 8'h50, 8'h01, 2'd0};
    vecs[44] = '{B_UP, 8'h00, 8'h50, 8'h01, 2'd0};

    reset = 1'b1;
    set_btns(5'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("reset_state", 64'({hora, min, seg, field, chs, busy}), 64'(28'h0));
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      press(vecs[i].btns);
      chk($sformatf("vec%0d", i), 64'({hora, min, seg, field, chs, busy}),
          64'({vecs[i].h, vecs[i].m, vecs[i].s, vecs[i].f, 1'b0, 1'b0}));
    end

    // Held up button yields exactly one increment
    press(B_LT);
    @(negedge clock);
    btn_up = 1'b1;
    repeat (50) @(posedge clock);
    @(negedge clock);
    btn_up = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("hold_once", 64'({seg, field}), 64'({8'h02, 2'd2}));

    // Load 12:34:56 from reset
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    repeat (12) press(B_UP);
    press(B_RT);
    repeat (34) press(B_UP);
    press(B_RT);
    repeat (56) press(B_UP);
    chk("set_123456", 64'({hora, min, seg, field}), 64'({8'h12, 8'h34, 8'h56, 2'd2}));

    // Store: strobe at N+2 only, busy for 112 cycles, edits frozen
    @(negedge clock);
    btn_save = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    chk("chs_early", 64'({chs, busy}), 64'(2'b00));
    @(posedge clock); #1;
    chk("chs_pulse", 64'({chs, busy}), 64'(2'b11));
    bcnt = 1; bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      btn_save = 1'b0;
      btn_up = (i < 90) && ((i % 8) < 3);
      @(posedge clock); #1;
      if (chs) bad++;
      if ({hora, min, seg} !== {8'h12, 8'h34, 8'h56}) bad++;
      if (busy) bcnt++;
      else break;
    end
    chk("busy_len", 64'(bcnt), 64'(112));
    chk("lock_hold", 64'(bad), 64'(0));
    btn_up = 1'b0;
    repeat (4) @(posedge clock); #1;
    chk("no_late_event", 64'(seg), 64'(8'h56));
    press(B_UP);
    chk("post_lock_up", 64'({hora, min, seg}), 64'({8'h12, 8'h34, 8'h57}));

    // Save and up together: store only; held buttons give nothing after lock
    @(negedge clock);
    set_btns(B_SAVE | B_UP);
    repeat (3) @(posedge clock); #1;
    chk("save_prio", 64'({chs, busy, hora, min, seg}), 64'({2'b11, 8'h12, 8'h34, 8'h57}));
    wait_idle();
    repeat (5) @(posedge clock); #1;
    chk("held_across_lock", 64'({chs, busy, seg}), 64'({2'b00, 8'h57}));
    @(negedge clock);
    set_btns(5'b0);
    repeat (3) @(posedge clock);
    press(B_UP | B_RT);
    chk("up_over_right", 64'({seg, field}), 64'({8'h58, 2'd2}));

    // Reset 20 cycles into lock
    @(negedge clock);
    btn_save = 1'b1;
    repeat (3) @(posedge clock);
    repeat (20) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    btn_save = 1'b0;
    @(posedge clock); #1;
    chk("reset_in_lock", 64'({hora, min, seg, field, chs, busy}), 64'(28'h0));
    @(negedge clock);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clock); #1;
      if (chs || busy) bad++;
    end
    chk("no_chs_after_reset", 64'(bad), 64'(0));
    @(negedge clock);
    btn_save = 1'b1;
    repeat (3) @(posedge clock); #1;
    chk("new_save", 64'({chs, busy}), 64'(2'b11));
    @(negedge clock);
    btn_save = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/time_set_editor.md
# time_set_editor

User-facing time-setting stage that feeds the RTC write sequencer. Holds hours, minutes and seconds as packed BCD, edits them from five push-button inputs with per-field wrap-around, and issues a single-cycle store strobe on `chs`. The downstream sequencer uses that strobe to copy `hora`, `min` and `seg` into RTC registers 0x23, 0x22 and 0x21. While that transfer runs, edits are frozen so the values written are stable.

## Interface
- `BUSY_CYCLES`, default 112: cycles edits stay locked after a store. Must cover one full three-register write pass downstream (≥106).
- `clock`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `btn_up`  in  1  increment the selected field; level, asynchronous to `clock`
- `btn_down`  in  1  decrement the selected field
- `btn_left`  in  1  move the field cursor left
- `btn_right`  in  1  move the field cursor right
- `btn_save`  in  1  request a store to the RTC
- `hora`  out  8  hours, BCD 0x00–0x23
- `min`  out  8  minutes, BCD 0x00–0x59
- `seg`  out  8  seconds, BCD 0x00–0x59
- `field`  out  2  cursor position: 0 = hours, 1 = minutes, 2 = seconds; 3 is never driven
- `chs`  out  1  one-cycle store strobe to the write sequencer
- `busy`  out  1  high while edits are locked

## Operation
- **Input conditioning:** each button passes through a 2-flop synchronizer and a third flop. An event is a rising edge: `s2 & ~s3`. Holding a button produces exactly one event. Buttons are already debounced upstream.
- **One action per cycle,** with fixed priority save > up > down > right > left. Lower-priority events in the same cycle are discarded, not queued.
- **States:**
  - EDIT (`busy=0`): all events honoured.
  - LOCK (`busy=1`): all events ignored and discarded; outputs hold.
- **Save event in EDIT:** `chs=1` for exactly one cycle, `busy=1`, lock counter loaded with `BUSY_CYCLES-1`, state goes to LOCK.
- **LOCK exit:** counter decrements each cycle. At 0 the state returns to EDIT and `busy=0` on the next edge.
- **Up/down arithmetic** is BCD on the selected field; a binary value is never stored.
  - Hours up: low digit +1. Low digit 9 → tens +1, low 0. 0x23 → 0x00.
  - Hours down: 0x00 → 0x23. Low digit 0 → tens −1, low 9.
  - Minutes/seconds up: low digit rollover as above. 0x59 → 0x00.
  - Minutes/seconds down: 0x00 → 0x59.
  - Up/down never touches the other fields; there is no carry between fields.
- **Cursor:** right steps 0→1→2→0; left steps 0→2→1→0.
- **`chs`** is never high on two consecutive cycles. The downstream sequencer retriggers on a held-high `chs`, so it must not see one.

## Timing
- **Reset values:** `hora=0x00`, `min=0x00`, `seg=0x00`, `field=0`, `chs=0`, `busy=0`, state EDIT, lock counter 0, all synchronizer flops 0.
- **Latency:** a button first sampled high at edge N has its effect visible on outputs after edge N+2. This applies to field, value, `chs` and `busy`.
- **Lock length:** `busy` is high for exactly `BUSY_CYCLES` cycles, from edge N+2 through edge N+1+`BUSY_CYCLES`.
- **Output stability:** `hora`/`min`/`seg` are constant from the `chs` edge until `busy` falls.
- **Button held across the end of LOCK:** produces no event, because the edge was consumed during LOCK. A new press is required.
- **Reset mid-LOCK:** returns to reset values on the next edge. No further `chs` is issued.
- **Reset and a button together:** reset wins. The synchronizers clear, so a still-held button gives no event afterwards.
- **Field value 3:** unreachable. If ever present, up/down/save are treated as hours.

## Test plan
1. Reset, then 24 `btn_up` presses on hours → `hora` steps 0x00…0x09, 0x10…0x23, then 0x00; `min`/`seg` stay 0x00.
2. `btn_right` once, `btn_down` once → `field=1`, `min=0x59`. Press down 10 more times → `min=0x49`. Press up once → `min=0x50`.
3. Press left from `field=0` → `field=2`. Hold `btn_up` high for 50 cycles → `seg` increments exactly once.
4. Set 0x12/0x34/0x56, press save at edge N → `chs` high only in the cycle after edge N+2. `busy` high for 112 cycles. Up presses during `busy` leave the values unchanged; a press after `busy` falls takes effect.
5. Raise `btn_save` and `btn_up` together → only the store happens (`chs` pulse, values unchanged). Raise `btn_up` and `btn_right` together → only the increment happens.
6. Assert reset 20 cycles into LOCK → all outputs return to reset values next edge; no `chs` until a new save press.
